// File: rtl/execute_md.sv
// E-stage multiply/divide unit: owns the HI/LO registers, sequences multi-cycle
// MULT/DIV operations and raises BusyE so the hazard logic can stall the pipe.
module execute_md #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       MdOpD,
    input  logic [WIDTH-1:0] RsDD,
    input  logic [WIDTH-1:0] RtDD,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic [WIDTH-1:0] ResultW,
    input  logic [WIDTH-1:0] ALUResultE,
    output logic [WIDTH-1:0] OutE,
    output logic             BusyE,
    output logic [WIDTH-1:0] HiE,
    output logic [WIDTH-1:0] LoE
);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [3:0]       MdOpE;
    logic [WIDTH-1:0] RsDE;
    logic [WIDTH-1:0] RtDE;
    logic [1:0]       state;
    logic [CNT_W-1:0] remCnt;
    logic [3:0]       opLat;
    logic [WIDTH-1:0] aLat;
    logic [WIDTH-1:0] bLat;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             isMulDiv;
    logic [CNT_W-1:0] opN;
    logic [3:0]       resOp;
    logic [WIDTH-1:0] resA;
    logic [WIDTH-1:0] resB;
    logic [2*WIDTH-1:0] mdRes;

    // Full-width product; sign/zero extension to 2*WIDTH makes the low half exact.
    function automatic logic [2*WIDTH-1:0] mulFull(input logic isSigned,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ea;
        logic signed [2*WIDTH-1:0] eb;
        ea = isSigned ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb = isSigned ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}; a zero divisor yields all-ones / dividend.
    function automatic logic [2*WIDTH-1:0] divUnsigned(input logic [WIDTH-1:0] n,
                                                       input logic [WIDTH-1:0] d);
        if (d == '0) begin
            return {n, {WIDTH{1'b1}}};
        end
        return {n % d, n / d};
    endfunction

    // Magnitude divide, then fix signs: quotient toward zero, remainder follows dividend.
    function automatic logic [2*WIDTH-1:0] divSigned(input logic signed [WIDTH-1:0] n,
                                                     input logic signed [WIDTH-1:0] d);
        logic [WIDTH-1:0]   magN;
        logic [WIDTH-1:0]   magD;
        logic [WIDTH-1:0]   q;
        logic [WIDTH-1:0]   r;
        logic [2*WIDTH-1:0] u;
        magN = n[WIDTH-1] ? -n : n;
        magD = d[WIDTH-1] ? -d : d;
        u = divUnsigned(magN, magD);
        r = u[2*WIDTH-1:WIDTH];
        q = u[WIDTH-1:0];
        if (d == '0) begin
            return {n, {WIDTH{1'b1}}};
        end
        if (n[WIDTH-1] ^ d[WIDTH-1]) begin
            q = -q;
        end
        if (n[WIDTH-1]) begin
            r = -r;
        end
        return {r, q};
    endfunction

    function automatic logic [2*WIDTH-1:0] mdResult(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        case (op)
            OP_MULT:  return mulFull(1'b1, a, b);
            OP_MULTU: return mulFull(1'b0, a, b);
            OP_DIV:   return divSigned(a, b);
            default:  return divUnsigned(a, b);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] fwdSel(input logic [1:0] sel,
                                                input logic [WIDTH-1:0] regVal,
                                                input logic [WIDTH-1:0] aluM,
                                                input logic [WIDTH-1:0] resW);
        case (sel)
            2'b01:   return resW;
            2'b10:   return aluM;
            default: return regVal;
        endcase
    endfunction

    // ---- D -> E register ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            MdOpE <= OP_NONE;
            RsDE  <= '0;
            RtDE  <= '0;
        end else if (FlushE) begin
            MdOpE <= OP_NONE;
        end else if (!StallE) begin
            MdOpE <= (MdOpD > OP_MTLO) ? OP_NONE : MdOpD;
            RsDE  <= RsDD;
            RtDE  <= RtDD;
        end
    end

    // ---- E stage: operand forwarding and result selection ----
    always_comb begin
        srcA     = fwdSel(ForwardAE, RsDE, ALUOutM, ResultW);
        srcB     = fwdSel(ForwardBE, RtDE, ALUOutM, ResultW);
        isMulDiv = (MdOpE == OP_MULT) || (MdOpE == OP_MULTU) ||
                   (MdOpE == OP_DIV)  || (MdOpE == OP_DIVU);
        opN      = ((MdOpE == OP_MULT) || (MdOpE == OP_MULTU)) ? CNT_W'(MUL_LAT)
                                                               : CNT_W'(DIV_LAT);
        BusyE    = (state == RUN) || ((state == IDLE) && isMulDiv);

        // A single-cycle op completes straight from the live operands.
        resOp = (state == IDLE) ? MdOpE : opLat;
        resA  = (state == IDLE) ? srcA  : aLat;
        resB  = (state == IDLE) ? srcB  : bLat;
        mdRes = mdResult(resOp, resA, resB);

        case (MdOpE)
            OP_MFHI: OutE = HiE;
            OP_MFLO: OutE = LoE;
            default: OutE = ALUResultE;
        endcase
    end

    // ---- Sequencer and HI/LO state ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            remCnt <= '0;
            opLat  <= OP_NONE;
            aLat   <= '0;
            bLat   <= '0;
            HiE    <= '0;
            LoE    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!FlushE) begin
                        if (isMulDiv) begin
                            if (opN == CNT_W'(1)) begin
                                {HiE, LoE} <= mdRes;
                                state      <= DONE;
                            end else begin
                                opLat  <= MdOpE;
                                aLat   <= srcA;
                                bLat   <= srcB;
                                remCnt <= opN - CNT_W'(1);
                                state  <= RUN;
                            end
                        end else if (!StallE && (MdOpE == OP_MTHI)) begin
                            HiE <= srcA;
                        end else if (!StallE && (MdOpE == OP_MTLO)) begin
                            LoE <= srcA;
                        end
                    end
                end
                RUN: begin
                    if (FlushE) begin
                        state <= IDLE;
                    end else if (remCnt == CNT_W'(1)) begin
                        {HiE, LoE} <= mdRes;
                        state      <= DONE;
                    end else begin
                        remCnt <= remCnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Leave only once the finished op moves on, so it never restarts.
                    if (FlushE || !StallE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_md.sv
// Randomized and directed checks of execute_md against a plain-arithmetic
// model of HI/LO, operand forwarding and busy-cycle counts.
module tb_execute_md;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;

    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

    logic             clk = 1'b0;
    logic             resetn;
    logic             StallE, FlushE;
    logic [3:0]       MdOpD;
    logic [WIDTH-1:0] RsDD, RtDD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [WIDTH-1:0] ALUOutM, ResultW, ALUResultE;
    logic [WIDTH-1:0] OutE, HiE, LoE;
    logic             BusyE;

    int               nChecks = 0;
    int               nFails  = 0;
    logic [31:0]      mHi, mLo;

    execute_md #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .resetn(resetn), .StallE(StallE), .FlushE(FlushE),
        .MdOpD(MdOpD), .RsDD(RsDD), .RtDD(RtDD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUOutM(ALUOutM), .ResultW(ResultW), .ALUResultE(ALUResultE),
        .OutE(OutE), .BusyE(BusyE), .HiE(HiE), .LoE(LoE)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                        input logic [31:0] aluM, input logic [31:0] resW);
        if (sel == 2'b01) return resW;
        if (sel == 2'b10) return aluM;
        return r;
    endfunction

    function automatic void refMd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        hi = '0;
        lo = '0;
        case (op)
            MULT: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
            DIV: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin hi = a % b; lo = a / b; end
            end
        endcase
    endfunction

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue one instruction from D, then follow it through E while it occupies the unit.
    task automatic doOp(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] aluM,
                        input logic [31:0] resW, input logic [31:0] aluRes);
        int          busy;
        int          expN;
        logic [31:0] a, b, eh, el;
        @(negedge clk);
        MdOpD = op; RsDD = rs; RtDD = rt; StallE = 1'b0; FlushE = 1'b0;
        @(negedge clk);
        MdOpD = NONE; RsDD = $urandom; RtDD = $urandom;
        ForwardAE = fa; ForwardBE = fb; ALUOutM = aluM; ResultW = resW; ALUResultE = aluRes;
        #1;
        a = fwd(fa, rs, aluM, resW);
        b = fwd(fb, rt, aluM, resW);
        if (op >= MULT && op <= DIVU) begin
            expN = (op <= MULTU) ? MUL_LAT : DIV_LAT;
            busy = 0;
            while (BusyE === 1'b1 && busy < 200) begin
                busy++;
                StallE = 1'b1;
                @(negedge clk);
                ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
                ALUOutM = $urandom; ResultW = $urandom;
                #1;
            end
            checkVal("busyLen", busy, expN);
            refMd(op, a, b, eh, el);
            mHi = eh; mLo = el;
            checkVal("mdHi", HiE, mHi);
            checkVal("mdLo", LoE, mLo);
            StallE = 1'b0;
        end else if (op == MFHI) begin
            checkVal("mfhiOut", OutE, mHi);
            checkVal("mfhiBusy", BusyE, 1'b0);
        end else if (op == MFLO) begin
            checkVal("mfloOut", OutE, mLo);
            checkVal("mfloBusy", BusyE, 1'b0);
        end else if (op == MTHI || op == MTLO) begin
            checkVal("mtBusy", BusyE, 1'b0);
            @(negedge clk);
            #1;
            if (op == MTHI) mHi = a; else mLo = a;
            checkVal("mtHi", HiE, mHi);
            checkVal("mtLo", LoE, mLo);
        end else begin
            checkVal("aluOut", OutE, aluRes);
            checkVal("aluBusy", BusyE, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; StallE = 1'b0; FlushE = 1'b0; MdOpD = NONE;
        RsDD = '0; RtDD = '0; ForwardAE = '0; ForwardBE = '0;
        ALUOutM = '0; ResultW = '0; ALUResultE = 32'h55;
        mHi = '0; mLo = '0;
        repeat (3) @(negedge clk);
        #1;
        checkVal("rstBusy", BusyE, 1'b0);
        checkVal("rstHi", HiE, 32'h0);
        checkVal("rstLo", LoE, 32'h0);
        checkVal("rstOut", OutE, 32'h55);
        resetn = 1'b1;

        // Directed values from the requirement examples
        doOp(MULT, 32'hFFFF_FFFE, 32'd3, 2'b00, 2'b00, 0, 0, 0);
        checkVal("multHiConst", HiE, 32'hFFFF_FFFF);
        checkVal("multLoConst", LoE, 32'hFFFF_FFFA);
        doOp(MFLO, 0, 0, 2'b00, 2'b00, 0, 0, 32'hABCD);
        doOp(DIVU, 32'd100, 32'd7, 2'b00, 2'b00, 0, 0, 0);
        checkVal("divuLoConst", LoE, 32'd14);
        checkVal("divuHiConst", HiE, 32'd2);
        doOp(DIV, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 0, 0, 0);
        checkVal("divNegLo", LoE, 32'hFFFF_FFFD);
        checkVal("divNegHi", HiE, 32'hFFFF_FFFF);
        doOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0, 0);
        checkVal("divOvfLo", LoE, 32'h8000_0000);
        checkVal("divOvfHi", HiE, 32'h0);
        doOp(DIVU, 32'd5, 32'd0, 2'b00, 2'b00, 0, 0, 0);
        checkVal("divZeroLo", LoE, 32'hFFFF_FFFF);
        checkVal("divZeroHi", HiE, 32'd5);
        doOp(MFHI, 0, 0, 2'b00, 2'b00, 0, 0, 32'h77);

        // MTHI through the M-stage forward, held by a stall before it may write
        @(negedge clk);
        MdOpD = MTHI; RsDD = 32'hDEAD; StallE = 1'b0;
        @(negedge clk);
        MdOpD = NONE; ForwardAE = 2'b10; ALUOutM = 32'h1234; StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkVal("mthiHeld", HiE, mHi);
        end
        StallE = 1'b0;
        @(negedge clk);
        #1;
        mHi = 32'h1234;
        checkVal("mthiFwd", HiE, mHi);
        doOp(MTLO, 32'h1, 32'h2, 2'b01, 2'b00, 32'h3, 32'h5A5A, 0);

        // Flush at the tenth busy cycle of a DIVU
        @(negedge clk);
        MdOpD = DIVU; RsDD = 32'd1000; RtDD = 32'd3; StallE = 1'b0; FlushE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            MdOpD = NONE; StallE = 1'b1;
            #1;
            checkVal("flushPreBusy", BusyE, 1'b1);
        end
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0; StallE = 1'b0;
        #1;
        checkVal("flushBusy", BusyE, 1'b0);
        checkVal("flushHi", HiE, mHi);
        checkVal("flushLo", LoE, mLo);
        repeat (40) @(negedge clk);
        #1;
        checkVal("flushLateHi", HiE, mHi);
        checkVal("flushLateLo", LoE, mLo);

        // Randomized instruction stream with random forwarding
        for (int n = 0; n < 60; n++) begin
            doOp(4'($urandom_range(0, 15)), pickVal(), pickVal(), 2'($urandom), 2'($urandom),
                 pickVal(), pickVal(), $urandom);
        end

        // Asynchronous reset while a MULT occupies the unit
        doOp(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0, 0);
        @(negedge clk);
        MdOpD = MULT; RsDD = 32'd7; RtDD = 32'd9; StallE = 1'b0;
        @(posedge clk);
        #2;
        MdOpD = NONE;
        checkVal("preRstBusy", BusyE, 1'b1);
        resetn = 1'b0;
        #1;
        mHi = '0; mLo = '0;
        checkVal("asyncBusy", BusyE, 1'b0);
        checkVal("asyncHi", HiE, mHi);
        checkVal("asyncLo", LoE, mLo);
        @(negedge clk);
        #1;
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkVal("postRstBusy", BusyE, 1'b0);
        checkVal("postRstHi", HiE, mHi);
        checkVal("postRstLo", LoE, mLo);
        doOp(MULT, 32'h10, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
